// File: rtl/usr_deserializer.sv
// Serial-to-parallel receiver: assembles N-bit words LSB- or MSB-first and hands them out over valid/ready.
// Optional parity bit per frame is compiled in with the USR_DESER_PARITY_EN macro.
module usr_deserializer #(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         enable,
  input  logic         dir,
  input  logic         s_data,
  input  logic         s_valid,
  output logic [N-1:0] Q,
  output logic         q_valid,
  input  logic         q_ready,
  output logic         busy,
  output logic         overrun,
  output logic         parity_err
);

  localparam int CW = $clog2(N + 1);

`ifdef USR_DESER_PARITY_EN
  typedef enum logic [1:0] {IDLE, RECV, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, RECV} state_t;
`endif

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic           dir_reg, dir_next;
  logic [N-1:0]   sr_reg, sr_next;
  logic [N-1:0]   q_reg, q_next;
  logic           qv_reg, qv_next;
  logic           ovr_reg, ovr_next;
  logic           busy_reg, busy_next;
`ifdef USR_DESER_PARITY_EN
  logic           perr_reg, perr_next;
  logic           word_perr;
`endif

  logic           accept;
  logic           eff_dir;
  logic [N-1:0]   shifted;
  logic           complete;
  logic [N-1:0]   word;

  assign accept  = enable && s_valid && !clear;
  // The first bit of a frame uses the live dir; later bits use the latched copy.
  assign eff_dir = (state_reg == IDLE) ? dir : dir_reg;
  assign shifted = eff_dir ? {sr_reg[N-2:0], s_data} : {s_data, sr_reg[N-1:1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      dir_reg   <= 1'b0;
      sr_reg    <= '0;
      q_reg     <= '0;
      qv_reg    <= 1'b0;
      ovr_reg   <= 1'b0;
      busy_reg  <= 1'b0;
`ifdef USR_DESER_PARITY_EN
      perr_reg  <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      dir_reg   <= dir_next;
      sr_reg    <= sr_next;
      q_reg     <= q_next;
      qv_reg    <= qv_next;
      ovr_reg   <= ovr_next;
      busy_reg  <= busy_next;
`ifdef USR_DESER_PARITY_EN
      perr_reg  <= perr_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    dir_next   = dir_reg;
    sr_next    = sr_reg;
    q_next     = q_reg;
    qv_next    = qv_reg;
    ovr_next   = ovr_reg;
    complete   = 1'b0;
    word       = sr_reg;
`ifdef USR_DESER_PARITY_EN
    perr_next  = perr_reg;
    word_perr  = 1'b0;
`endif

    if (accept) begin
      case (state_reg)
        IDLE: begin
          dir_next   = dir;
          sr_next    = shifted;
          cnt_next   = CW'(1);
          state_next = RECV;
        end
        RECV: begin
          sr_next  = shifted;
          cnt_next = cnt_reg + CW'(1);
          if (cnt_reg == CW'(N - 1)) begin
`ifdef USR_DESER_PARITY_EN
            state_next = PAR;
`else
            complete   = 1'b1;
            word       = shifted;
            state_next = IDLE;
            cnt_next   = '0;
`endif
          end
        end
`ifdef USR_DESER_PARITY_EN
        PAR: begin
          // Parity bit is not shifted in; even parity over data plus parity bit.
          complete   = 1'b1;
          word       = sr_reg;
          word_perr  = ^{sr_reg, s_data};
          state_next = IDLE;
          cnt_next   = '0;
        end
`endif
        default: state_next = IDLE;
      endcase
    end

    if (complete) begin
      if (!qv_reg || q_ready) begin
        q_next    = word;
        qv_next   = 1'b1;
`ifdef USR_DESER_PARITY_EN
        perr_next = word_perr;
`endif
      end else begin
        ovr_next  = 1'b1;
      end
    end else if (qv_reg && q_ready) begin
      qv_next = 1'b0;
    end

    if (clear) begin
      state_next = IDLE;
      cnt_next   = '0;
      sr_next    = '0;
      q_next     = '0;
      qv_next    = 1'b0;
      ovr_next   = 1'b0;
`ifdef USR_DESER_PARITY_EN
      perr_next  = 1'b0;
`endif
    end

    busy_next = (state_next != IDLE);
  end

  assign Q       = q_reg;
  assign q_valid = qv_reg;
  assign busy    = busy_reg;
  assign overrun = ovr_reg;
`ifdef USR_DESER_PARITY_EN
  assign parity_err = perr_reg;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_usr_deserializer.sv
// Self-checking bench for usr_deserializer: directed scenarios plus random traffic against a
// frame-level reference model (bit queue -> word by positional arithmetic).
module tb_usr_deserializer;
  localparam int N = 6;
`ifdef USR_DESER_PARITY_EN
  localparam int FRAME = N + 1;
`else
  localparam int FRAME = N;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         clear = 1'b0;
  logic         enable = 1'b0;
  logic         dir = 1'b0;
  logic         s_data = 1'b0;
  logic         s_valid = 1'b0;
  logic [N-1:0] Q;
  logic         q_valid;
  logic         q_ready = 1'b0;
  logic         busy;
  logic         overrun;
  logic         parity_err;

  int checks = 0;
  int failures = 0;

  usr_deserializer #(.N(N)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .enable(enable), .dir(dir),
    .s_data(s_data), .s_valid(s_valid), .Q(Q), .q_valid(q_valid), .q_ready(q_ready),
    .busy(busy), .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [N-1:0] m_q = '0;
  logic         m_qv = 1'b0;
  logic         m_ovr = 1'b0;
  logic         m_perr = 1'b0;
  bit           m_fdir = 1'b0;
  bit           m_bits[$];

  function automatic logic m_busy();
    return m_bits.size() != 0;
  endfunction

  task automatic m_reset();
    m_bits.delete();
    m_q = '0; m_qv = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
  endtask

  // Apply one cycle of inputs, step the model at the edge, return 1 ns after it.
  task automatic drive(input logic en, input logic sv, input logic sd, input logic d,
                       input logic rdy, input logic clr);
    int w;
    bit p;
    bit complete;
    enable = en; s_valid = sv; s_data = sd; dir = d; q_ready = rdy; clear = clr;
    @(posedge clk);
    complete = 1'b0;
    w = 0;
    p = 1'b0;
    if (clr) begin
      m_reset();
    end else begin
      if (en && sv) begin
        if (m_bits.size() == 0) m_fdir = d;
        m_bits.push_back(sd);
        if (m_bits.size() == FRAME) begin
          for (int i = 0; i < N; i++) begin
            if (m_bits[i]) w += 1 << (m_fdir ? (N - 1 - i) : i);
            p ^= m_bits[i];
          end
          if (FRAME > N) p ^= m_bits[N];
          else p = 1'b0;
          complete = 1'b1;
          m_bits.delete();
        end
      end
      if (complete) begin
        if (!m_qv || rdy) begin
          m_q = N'(w); m_qv = 1'b1; m_perr = p;
          $display("txn word=%b dir=%0d perr=%0d delivered", N'(w), m_fdir, p);
        end else begin
          m_ovr = 1'b1;
          $display("txn word=%b dir=%0d perr=%0d dropped", N'(w), m_fdir, p);
        end
      end else if (m_qv && rdy) begin
        m_qv = 1'b0;
      end
    end
    #1;
  endtask

  // seq[N-1] is transmitted first; pbit is sent only when parity frames are in use.
  task automatic send_bits(input logic [N-1:0] seq, input logic d, input logic rdy,
                           input logic pbit);
    for (int i = N - 1; i >= 0; i--) drive(1'b1, 1'b1, seq[i], d, rdy, 1'b0);
    if (FRAME > N) drive(1'b1, 1'b1, pbit, d, rdy, 1'b0);
  endtask

  task automatic test_reset();
    logic [N-1:0] seq;
    #12;
    checks++;
    if ({Q, q_valid, busy, overrun, parity_err} !== '0) begin
      failures++;
      $display("FAIL reset_initial got=%b required=0", {Q, q_valid, busy, overrun, parity_err});
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    seq = 6'b101101;
    for (int i = N - 1; i >= N - 3; i--) drive(1'b1, 1'b1, seq[i], 1'b1, 1'b1, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_busy_before got=%b required=1", busy);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({Q, busy, q_valid} !== '0) begin
      failures++;
      $display("FAIL reset_midframe Q=%b busy=%b q_valid=%b required all 0", Q, busy, q_valid);
    end
    m_reset();
    #9;
    reset_n = 1'b1;
    seq = 6'b011001;
    send_bits(seq, 1'b1, 1'b1, ^seq);
    checks++;
    if (Q !== 6'b011001 || q_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_fresh_frame Q=%b q_valid=%b required 011001/1", Q, q_valid);
    end
  endtask

  task automatic test_bit_order();
    logic [N-1:0] seq;
    seq = 6'b110010;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_bits(seq, 1'b1, 1'b1, ^seq);
    checks++;
    if (Q !== 6'b110010 || q_valid !== 1'b1) begin
      failures++;
      $display("FAIL order_msb Q=%b q_valid=%b required 110010/1", Q, q_valid);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (q_valid !== 1'b0) begin
      failures++;
      $display("FAIL order_msb_pulse q_valid=%b required 0", q_valid);
    end
    send_bits(seq, 1'b0, 1'b1, ^seq);
    checks++;
    if (Q !== 6'b010011 || q_valid !== 1'b1) begin
      failures++;
      $display("FAIL order_lsb Q=%b q_valid=%b required 010011/1", Q, q_valid);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (q_valid !== 1'b0) begin
      failures++;
      $display("FAIL order_lsb_pulse q_valid=%b required 0", q_valid);
    end
  endtask

  task automatic test_overrun();
    send_bits(6'b101101, 1'b1, 1'b0, 1'b0);
    checks++;
    if (Q !== 6'b101101 || q_valid !== 1'b1 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_first Q=%b q_valid=%b overrun=%b required 101101/1/0", Q, q_valid, overrun);
    end
    send_bits(6'b110010, 1'b1, 1'b0, 1'b1);
    checks++;
    if (Q !== 6'b101101 || q_valid !== 1'b1 || overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_drop Q=%b q_valid=%b overrun=%b required 101101/1/1", Q, q_valid, overrun);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (q_valid !== 1'b0 || overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_drain q_valid=%b overrun=%b required 0/1", q_valid, overrun);
    end
  endtask

  task automatic test_enable();
    logic [N-1:0] seq;
    seq = 6'b011010;
    for (int i = N - 1; i >= N - 3; i--) drive(1'b1, 1'b1, seq[i], 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, k[0], 1'b0, 1'b1, 1'b0);
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL enable_pause_busy k=%0d busy=%b required 1", k, busy);
      end
    end
    for (int i = N - 4; i >= 0; i--) drive(1'b1, 1'b1, seq[i], 1'b0, 1'b1, 1'b0);
    if (FRAME > N) drive(1'b1, 1'b1, ^seq, 1'b0, 1'b1, 1'b0);
    checks++;
    if (Q !== 6'b011010 || q_valid !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL enable_resume Q=%b q_valid=%b busy=%b required 011010/1/0", Q, q_valid, busy);
    end
  endtask

  task automatic test_clear();
    logic [N-1:0] seq;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_bits(6'b111000, 1'b1, 1'b0, 1'b0);
    send_bits(6'b000111, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (q_valid !== 1'b1 || overrun !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL clear_setup q_valid=%b overrun=%b busy=%b required 1/1/1", q_valid, overrun, busy);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({Q, q_valid, busy, overrun, parity_err} !== '0) begin
      failures++;
      $display("FAIL clear_outputs got=%b required=0", {Q, q_valid, busy, overrun, parity_err});
    end
    seq = 6'b100110;
    send_bits(seq, 1'b0, 1'b1, ^seq);
    checks++;
    if (Q !== 6'b011001 || q_valid !== 1'b1) begin
      failures++;
      $display("FAIL clear_next_frame Q=%b q_valid=%b required 011001/1", Q, q_valid);
    end
  endtask

`ifdef USR_DESER_PARITY_EN
  task automatic test_parity();
    send_bits(6'b101101, 1'b1, 1'b1, 1'b0);
    checks++;
    if (Q !== 6'b101101 || parity_err !== 1'b0) begin
      failures++;
      $display("FAIL parity_good Q=%b parity_err=%b required 101101/0", Q, parity_err);
    end
    send_bits(6'b101101, 1'b1, 1'b1, 1'b1);
    checks++;
    if (Q !== 6'b101101 || parity_err !== 1'b1 || q_valid !== 1'b1) begin
      failures++;
      $display("FAIL parity_bad Q=%b parity_err=%b q_valid=%b required 101101/1/1", Q, parity_err, q_valid);
    end
  endtask
`endif

  task automatic test_random();
    logic en, sv, sd, d, rdy, clr;
    for (int c = 0; c < 1500; c++) begin
      en  = ($urandom_range(0, 3) != 0);
      sv  = ($urandom_range(0, 4) != 0);
      sd  = 1'($urandom_range(0, 1));
      d   = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 99) == 0);
      drive(en, sv, sd, d, rdy, clr);
      checks++;
      if ({Q, q_valid, busy, overrun, parity_err} !== {m_q, m_qv, m_busy(), m_ovr, m_perr}) begin
        failures++;
        $display("FAIL random cyc=%0d got Q=%b v=%b b=%b o=%b p=%b required Q=%b v=%b b=%b o=%b p=%b",
                 c, Q, q_valid, busy, overrun, parity_err, m_q, m_qv, m_busy(), m_ovr, m_perr);
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_bits(6'b100001, 1'b1, 1'b1, 1'b0);
    send_bits(6'b010110, 1'b0, 1'b1, 1'b1);
    checks++;
    if (Q !== 6'b011010 || q_valid !== 1'b1 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back Q=%b q_valid=%b overrun=%b required 011010/1/0", Q, q_valid, overrun);
    end
  endtask

  initial begin
    test_reset();
    test_bit_order();
    test_overrun();
    test_enable();
    test_clear();
`ifdef USR_DESER_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
